// File: rtl/pkt_demux_avlstrm_pkg.sv
// Shared types for the packet-atomic Avalon-ST demultiplexer: beat record,
// FSM state encoding and default widths.
package pkt_demux_pkg;

   localparam int PKT_DATA_W  = 512;
   localparam int PKT_EMPTY_W = 6;

   typedef struct packed {
      logic [PKT_DATA_W-1:0]  data;
      logic                   sop;
      logic                   eop;
      logic [PKT_EMPTY_W-1:0] empty;
   } avl_beat_t;

   typedef enum logic [1:0] {
      IDLE,
      FWD,
      DROP
   } demux_st_t;

endpackage

// File: rtl/pkt_demux_avlstrm_if.sv
// Avalon-ST bundle carrying N parallel lanes; lane i occupies slice i of each
// flattened field. The demux input uses N = 1, the output side N = NUM_OUT.
interface pkt_demux_avlstrm_if
   import pkt_demux_pkg::*;
#(
   parameter int N       = 1,
   parameter int DATA_W  = PKT_DATA_W,
   parameter int EMPTY_W = PKT_EMPTY_W,
   parameter int CH_W    = 3
);
   logic [N*DATA_W-1:0]  data;
   logic [N-1:0]         valid;
   logic [N-1:0]         ready;
   logic [N-1:0]         sop;
   logic [N-1:0]         eop;
   logic [N*EMPTY_W-1:0] empty;
   logic [N*CH_W-1:0]    channel;

   modport master (output data, valid, sop, eop, empty, channel, input ready);
   modport slave  (input data, valid, sop, eop, empty, channel, output ready);
endinterface

// File: rtl/pkt_demux_avlstrm_skid_buf.sv
// Two-entry register FIFO feeding one demux output. Output valid and the
// upstream "room" flag both come straight from flops.
module avlstrm_skid_buf
   import pkt_demux_pkg::*;
#(
   parameter type beat_t = avl_beat_t
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  beat_t in_beat,
   output logic  room,
   output logic  out_valid,
   input  logic  out_ready,
   output beat_t out_beat
);
   logic [1:0] cnt_p1;
   logic [1:0] cnt_nxt;
   logic       vld_p1;
   logic       room_p1;
   logic       pop;
   beat_t      head_p1;
   beat_t      tail_p1;

   assign pop = vld_p1 & out_ready;

   always_comb begin
      cnt_nxt = cnt_p1 + {1'b0, push} - {1'b0, pop};
   end

   // Head is the presented beat; tail only fills while head is stalled.
   always_ff @(posedge clk) begin
      if (push && ((cnt_p1 == 2'd0) || ((cnt_p1 == 2'd1) && pop))) begin
         head_p1 <= in_beat;
      end else if (pop && (cnt_p1 == 2'd2)) begin
         head_p1 <= tail_p1;
      end
      if (push && (((cnt_p1 == 2'd1) && !pop) || ((cnt_p1 == 2'd2) && pop))) begin
         tail_p1 <= in_beat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p1  <= 2'd0;
         vld_p1  <= 1'b0;
         room_p1 <= 1'b0;
      end else begin
         cnt_p1  <= cnt_nxt;
         vld_p1  <= (cnt_nxt != 2'd0);
         room_p1 <= (cnt_nxt < 2'd2);
      end
   end

   assign room      = room_p1;
   assign out_valid = vld_p1;
   assign out_beat  = head_p1;

endmodule

// File: rtl/pkt_demux_avlstrm.sv
// Packet-atomic 1-to-NUM_OUT Avalon-ST demux: the SOP beat's channel picks the
// destination for the whole packet; invalid channels are dropped and counted.
module pkt_demux_avlstrm
   import pkt_demux_pkg::*;
#(
   parameter int NUM_OUT = 3,
   parameter int DATA_W  = PKT_DATA_W,
   parameter int EMPTY_W = PKT_EMPTY_W,
   parameter int CH_W    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   pkt_demux_avlstrm_if.slave   in_st,
   pkt_demux_avlstrm_if.master  out_st,
   output logic [31:0]          drop_cnt,
   output logic [31:0]          err_cnt
);
   localparam int CH_N = 1 << CH_W;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
   } beat_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   demux_st_t          st;
   logic [CH_W-1:0]    cur_ch;
   logic               run;
   logic [NUM_OUT-1:0] room;
   logic [NUM_OUT-1:0] push;
   logic [CH_N-1:0]    room_x;
   logic [CH_W-1:0]    dest;
   logic               sop;
   logic               eop;
   logic               ch_ok;
   logic               rdy;
   logic               acc;
   logic               fwd;
   beat_t              in_beat;

   assign sop     = in_st.sop[0];
   assign eop     = in_st.eop[0];
   assign ch_ok   = 32'(in_st.channel) < NUM_OUT;
   assign room_x  = CH_N'(room);
   assign in_beat = '{data: in_st.data, sop: sop, eop: eop, empty: in_st.empty};

   // Only the destination's own buffer throttles the input; stray and dropped
   // beats are always taken so they cannot block other outputs.
   always_comb begin
      rdy = 1'b0;
      if (run && !rst) begin
         unique case (st)
            IDLE:    rdy = (!sop || !ch_ok) ? 1'b1 : room_x[in_st.channel];
            FWD:     rdy = room_x[cur_ch];
            DROP:    rdy = 1'b1;
            default: rdy = 1'b0;
         endcase
      end
   end

   assign in_st.ready = rdy;
   assign acc  = in_st.valid[0] & rdy;
   assign fwd  = acc & (((st == IDLE) & sop & ch_ok) | (st == FWD));
   assign dest = (st == IDLE) ? in_st.channel : cur_ch;

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= IDLE;
         cur_ch   <= '0;
         run      <= 1'b0;
         drop_cnt <= 32'd0;
         err_cnt  <= 32'd0;
      end else begin
         run <= 1'b1;
         if (acc) begin
            unique case (st)
               IDLE: begin
                  if (!sop) begin
                     err_cnt <= sat_inc(err_cnt);
                  end else if (ch_ok) begin
                     cur_ch <= in_st.channel;
                     if (!eop) st <= FWD;
                  end else begin
                     drop_cnt <= sat_inc(drop_cnt);
                     if (!eop) st <= DROP;
                  end
               end
               FWD: begin
                  if (sop) err_cnt <= sat_inc(err_cnt);
                  if (eop) st <= IDLE;
               end
               DROP: begin
                  if (eop) st <= IDLE;
               end
               default: st <= IDLE;
            endcase
         end
      end
   end

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
      beat_t ob;

      assign push[i] = fwd && (dest == CH_W'(i));

      avlstrm_skid_buf #(.beat_t(beat_t)) u_skid (
         .clk       (clk),
         .rst       (rst),
         .push      (push[i]),
         .in_beat   (in_beat),
         .room      (room[i]),
         .out_valid (out_st.valid[i]),
         .out_ready (out_st.ready[i]),
         .out_beat  (ob)
      );

      assign out_st.data[i*DATA_W +: DATA_W]    = ob.data;
      assign out_st.sop[i]                      = ob.sop;
      assign out_st.eop[i]                      = ob.eop;
      assign out_st.empty[i*EMPTY_W +: EMPTY_W] = ob.empty;
      assign out_st.channel[i*CH_W +: CH_W]     = CH_W'(i);
   end

endmodule

// File: tb/tb_pkt_demux_avlstrm.sv
// Bench for pkt_demux_avlstrm: directed scenarios plus randomized packets,
// checked against a packet-level model holding per-output beat queues.
module tb_pkt_demux_avlstrm;
   localparam int NUM_OUT = 3;
   localparam int DATA_W  = 64;
   localparam int EMPTY_W = 3;
   localparam int CH_W    = 3;
   localparam int BOUND   = 200;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
   } tb_beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] drop_cnt;
   logic [31:0] err_cnt;

   pkt_demux_avlstrm_if #(.N(1), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CH_W(CH_W)) in_if ();
   pkt_demux_avlstrm_if #(.N(NUM_OUT), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CH_W(CH_W)) out_if ();

   pkt_demux_avlstrm #(
      .NUM_OUT (NUM_OUT),
      .DATA_W  (DATA_W),
      .EMPTY_W (EMPTY_W),
      .CH_W    (CH_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_st    (in_if),
      .out_st   (out_if),
      .drop_cnt (drop_cnt),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: what each output buffer should hold, packet context, counters.
   tb_beat_t    q [NUM_OUT][$];
   tb_beat_t    last_pop [NUM_OUT];
   bit          m_armed = 0;
   bit          m_run = 0;
   bit          m_in_pkt = 0;
   int          m_dest = 0;
   logic [31:0] exp_drop = 0;
   logic [31:0] exp_err = 0;

   function automatic bit exp_ready();
      int ch;
      ch = int'(in_if.channel);
      if (rst || !m_run) return 1'b0;
      if (!m_in_pkt) begin
         if (!in_if.sop[0] || ch >= NUM_OUT) return 1'b1;
         return q[ch].size() < 2;
      end
      if (m_dest < 0) return 1'b1;
      return q[m_dest].size() < 2;
   endfunction

   function automatic tb_beat_t out_beat(input int i);
      return {out_if.data[i*DATA_W +: DATA_W], out_if.sop[i], out_if.eop[i],
              out_if.empty[i*EMPTY_W +: EMPTY_W]};
   endfunction

   task automatic model_accept();
      tb_beat_t b;
      int ch;
      b  = '{data: in_if.data, sop: in_if.sop[0], eop: in_if.eop[0], empty: in_if.empty};
      ch = int'(in_if.channel);
      if (!m_in_pkt) begin
         if (!b.sop) begin
            exp_err++;
         end else if (ch < NUM_OUT) begin
            q[ch].push_back(b);
            if (!b.eop) begin m_in_pkt = 1; m_dest = ch; end
         end else begin
            exp_drop++;
            if (!b.eop) begin m_in_pkt = 1; m_dest = -1; end
         end
      end else begin
         if (m_dest >= 0) begin
            q[m_dest].push_back(b);
            if (b.sop) exp_err++;
         end
         if (b.eop) m_in_pkt = 0;
      end
   endtask

   // Negedge values are exactly what the next rising edge will act on.
   always @(negedge clk) begin
      if (m_armed) begin
         chk("drop_cnt", drop_cnt, exp_drop);
         chk("err_cnt", err_cnt, exp_err);
         chk("in_ready", in_if.ready[0], exp_ready());
         for (int i = 0; i < NUM_OUT; i++) begin
            chk($sformatf("out_valid%0d", i), out_if.valid[i], q[i].size() != 0);
            if (out_if.valid[i] && q[i].size() != 0)
               chk($sformatf("out_beat%0d", i), out_beat(i), q[i][0]);
         end
      end
      if (rst) begin
         for (int i = 0; i < NUM_OUT; i++) q[i].delete();
         m_run    = 0;
         m_in_pkt = 0;
         exp_drop = 0;
         exp_err  = 0;
         m_armed  = 1;
      end else if (m_armed) begin
         for (int i = 0; i < NUM_OUT; i++)
            if (out_if.valid[i] && out_if.ready[i] && q[i].size() != 0)
               last_pop[i] = q[i].pop_front();
         if (in_if.valid[0] && in_if.ready[0]) begin
            acc_total++;
            model_accept();
         end
         m_run = 1;
      end
   end

   task automatic send_beat(input int ch, input bit sop, input bit eop,
                            input logic [EMPTY_W-1:0] emp, input logic [DATA_W-1:0] d);
      int n;
      in_if.data    = d;
      in_if.valid   = 1'b1;
      in_if.sop     = sop;
      in_if.eop     = eop;
      in_if.empty   = emp;
      in_if.channel = CH_W'(ch);
      n = 0;
      @(negedge clk);
      while (!in_if.ready[0] && n < BOUND) begin
         n++;
         @(negedge clk);
      end
      if (n >= BOUND) chk("send_timeout", n, 0);
      @(posedge clk);
      #1;
      in_if.valid = 1'b0;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
   endtask

   task automatic send_pkt(input int ch, input int len, input int mid_sop,
                           input logic [EMPTY_W-1:0] last_emp);
      for (int b = 0; b < len; b++)
         send_beat(ch, (b == 0) || (b == mid_sop), b == len - 1,
                   (b == len - 1) ? last_emp : EMPTY_W'($urandom), {$urandom, $urandom});
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, base, len, ch, mid;
      bit done;
      in_if.valid   = 1'b0;
      in_if.sop     = 1'b0;
      in_if.eop     = 1'b0;
      in_if.data    = '0;
      in_if.empty   = '0;
      in_if.channel = '0;
      out_if.ready  = '1;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_if.valid, 0);
      chk("rst_in_ready", in_if.ready, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_err_cnt", err_cnt, 0);
      @(posedge clk);
      #1;

      // 1: four-beat ch1 packet, output one cycle after acceptance
      fork
         send_pkt(1, 4, -1, 3'd5);
         begin
            @(negedge clk);
            @(negedge clk);
            chk("t1_latency_valid", out_if.valid, 3'b010);
            chk("t1_first_sop", out_if.sop[1], 1);
         end
      join
      wait_cycles(3);
      chk("t1_last_eop", last_pop[1].eop, 1);
      chk("t1_last_empty", last_pop[1].empty, 5);

      // 2: single-beat ch0 then ch2 back-to-back, no bubbles
      t0 = cyc;
      send_pkt(0, 1, -1, 3'd2);
      send_pkt(2, 3, -1, 3'd1);
      chk("t2_no_bubble", cyc - t0, 4);
      wait_cycles(3);

      // 3: ch2 stalled for 10 cycles, ch0 packet queued behind it
      out_if.ready = 3'b011;
      base = acc_total;
      fork
         begin
            send_pkt(2, 5, -1, 3'd3);
            send_pkt(0, 2, -1, 3'd0);
         end
         begin
            repeat (10) @(posedge clk);
            #1 out_if.ready = 3'b111;
         end
         begin
            repeat (6) @(negedge clk);
            chk("t3_two_accepted", acc_total - base, 2);
            chk("t3_in_ready_low", in_if.ready, 0);
         end
      join
      chk("t3_total_accepted", acc_total - base, 7);
      wait_cycles(5);

      // 4: invalid channel dropped without stalling
      t0 = cyc;
      send_pkt(5, 3, -1, 3'd0);
      chk("t4_no_stall", cyc - t0, 3);
      wait_cycles(2);
      chk("t4_drop_cnt", drop_cnt, 1);

      // 5: stray beat in idle, SOP mid-packet
      send_beat(1, 1'b0, 1'b0, 3'd0, 64'hDEAD_0000_BEEF_0001);
      send_pkt(0, 3, 1, 3'd4);
      wait_cycles(3);
      chk("t5_err_cnt", err_cnt, 2);

      // 6: reset on beat 2 of a ch1 packet
      send_beat(1, 1'b1, 1'b0, 3'd0, 64'h1111_2222_3333_4444);
      send_beat(1, 1'b0, 1'b0, 3'd0, 64'h5555_6666_7777_8888);
      in_if.valid = 1'b1;
      in_if.data  = 64'h9999_AAAA_BBBB_CCCC;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_if.valid = 1'b0;
      @(negedge clk);
      chk("t6_out_valid", out_if.valid, 0);
      chk("t6_in_ready", in_if.ready, 0);
      chk("t6_drop_cnt", drop_cnt, 0);
      chk("t6_err_cnt", err_cnt, 0);
      @(posedge clk);
      #1;
      send_pkt(1, 4, -1, 3'd6);
      wait_cycles(4);

      // Randomized traffic with random per-output back-pressure
      done = 0;
      fork
         begin
            for (int p = 0; p < 150; p++) begin
               wait_cycles($urandom_range(0, 2));
               if ($urandom_range(0, 9) == 0)
                  send_beat($urandom_range(0, 7), 1'b0, 1'($urandom), 3'($urandom),
                            {$urandom, $urandom});
               ch  = $urandom_range(0, 7);
               len = $urandom_range(1, 6);
               mid = (ch < NUM_OUT && len > 1 && $urandom_range(0, 7) == 0) ?
                     $urandom_range(1, len - 1) : -1;
               send_pkt(ch, len, mid, 3'($urandom));
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_if.ready = NUM_OUT'($urandom | $urandom);
            end
         end
      join
      out_if.ready = '1;
      wait_cycles(20);
      for (int i = 0; i < NUM_OUT; i++) chk($sformatf("drain_q%0d", i), q[i].size(), 0);
      chk("final_drop_cnt", drop_cnt, exp_drop);
      chk("final_err_cnt", err_cnt, exp_err);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
